// File: rtl/audio_pkg.sv
// Shared types for the codec audio receive path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package audio_pkg;

  localparam int DATA_W_DEF = 16;

  typedef enum logic [0:0] {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } ch_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } rx_state_t;

endpackage

// File: rtl/sync_edge.sv
// Input synchroniser with a trailing register; q is either the level or a rising-edge pulse.
// Latency: STAGES+1 clk from din to q (level and rise modes line up cycle-for-cycle).
// Backpressure: none; free-running.
// Ports: clk/rst (async active-high), din asynchronous input, q registered output.
module sync_edge #(
  parameter int   STAGES = 2,
  parameter logic RISE   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;
  logic              out_q, out_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    prev_d = sync_q[STAGES-1];
    // Level mode delays by the same one register as the edge detector, so a
    // level sampled alongside a rise pulse belongs to the same bclk edge.
    out_d  = RISE ? (sync_q[STAGES-1] & ~prev_q) : sync_q[STAGES-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      out_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      out_q  <= out_d;
    end
  end

  assign q = out_q;

endmodule

// File: rtl/i2s_adc_rx.sv
// I2S ADC receiver: oversamples bclk/adclrc/adcdat on mclk and deserialises MSB-first words.
// Latency: sample_valid SYNC_STAGES+2 mclk after raw bclk is first sampled high for the LSB.
// Backpressure: none; outputs are single-cycle pulses with held data registers.
// Ports: mclk/rst; bclk, adclrc, adcdat from codec pins; sample_* per word, left/right_data held,
//        pair_valid on a right word that follows a left word, frame_err on a truncated word.
module i2s_adc_rx
  import audio_pkg::*;
#(
  parameter int   DATA_W      = DATA_W_DEF,
  parameter int   SYNC_STAGES = 2,
  parameter logic LEFT_LRC    = 1'b0
) (
  input  logic              mclk,
  input  logic              rst,
  input  logic              bclk,
  input  logic              adclrc,
  input  logic              adcdat,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_ch,
  output logic              sample_valid,
  output logic [DATA_W-1:0] left_data,
  output logic [DATA_W-1:0] right_data,
  output logic              pair_valid,
  output logic              frame_err
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);

  logic bclk_rise, lrc_s, dat_s;

  sync_edge #(.STAGES(SYNC_STAGES), .RISE(1'b1)) u_bclk (.clk(mclk), .rst(rst), .din(bclk),   .q(bclk_rise));
  sync_edge #(.STAGES(SYNC_STAGES), .RISE(1'b0)) u_lrc  (.clk(mclk), .rst(rst), .din(adclrc), .q(lrc_s));
  sync_edge #(.STAGES(SYNC_STAGES), .RISE(1'b0)) u_dat  (.clk(mclk), .rst(rst), .din(adcdat), .q(dat_s));

  rx_state_t         state_q, state_d;
  ch_t               ch_q, ch_d;
  logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              lrc_prev_q, lrc_prev_d;
  logic              lrc_vld_q, lrc_vld_d;
  logic              done_q, done_d;
  logic              left_seen_q, left_seen_d;
  logic [DATA_W-1:0] sample_data_q, sample_data_d;
  logic              sample_ch_q, sample_ch_d;
  logic              sample_valid_q, sample_valid_d;
  logic [DATA_W-1:0] left_data_q, left_data_d;
  logic [DATA_W-1:0] right_data_q, right_data_d;
  logic              pair_valid_q, pair_valid_d;
  logic              frame_err_q, frame_err_d;

  always_comb begin
    state_d        = state_q;
    ch_d           = ch_q;
    bitcnt_d       = bitcnt_q;
    shreg_d        = shreg_q;
    lrc_prev_d     = lrc_prev_q;
    lrc_vld_d      = lrc_vld_q;
    done_d         = 1'b0;
    left_seen_d    = left_seen_q;
    sample_data_d  = sample_data_q;
    sample_ch_d    = sample_ch_q;
    sample_valid_d = 1'b0;
    left_data_d    = left_data_q;
    right_data_d   = right_data_q;
    pair_valid_d   = 1'b0;
    frame_err_d    = 1'b0;

    // Publish the word completed on the previous cycle; shreg is stable here
    // because bclk rises are at least two mclk apart.
    if (done_q) begin
      sample_valid_d = 1'b1;
      sample_data_d  = shreg_q;
      sample_ch_d    = ch_q;
      pair_valid_d   = (ch_q == CH_RIGHT) && left_seen_q;
      left_seen_d    = (ch_q == CH_LEFT);
      if (ch_q == CH_LEFT) left_data_d  = shreg_q;
      else                 right_data_d = shreg_q;
    end

    if (bclk_rise) begin
      lrc_prev_d = lrc_s;
      // The first rise after reset only captures the lrc level, so a reset
      // released mid-frame cannot fake an lrc edge from the cleared register.
      lrc_vld_d  = 1'b1;
      if (lrc_vld_q && (lrc_s != lrc_prev_q)) begin
        // This rise carries the I2S delay slot; its bit is discarded.
        ch_d     = (lrc_s == LEFT_LRC) ? CH_LEFT : CH_RIGHT;
        bitcnt_d = '0;
        state_d  = SHIFT;
        if (state_q == SHIFT) begin
          frame_err_d = 1'b1;
          left_seen_d = 1'b0;
        end
      end else if (state_q == SHIFT) begin
        shreg_d  = {shreg_q[DATA_W-2:0], dat_s};
        bitcnt_d = bitcnt_q + CNT_W'(1);
        if (bitcnt_q == LAST_BIT) begin
          done_d  = 1'b1;
          state_d = HOLD;
        end
      end
    end
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      ch_q           <= CH_LEFT;
      bitcnt_q       <= '0;
      shreg_q        <= '0;
      lrc_prev_q     <= 1'b0;
      lrc_vld_q      <= 1'b0;
      done_q         <= 1'b0;
      left_seen_q    <= 1'b0;
      sample_data_q  <= '0;
      sample_ch_q    <= 1'b0;
      sample_valid_q <= 1'b0;
      left_data_q    <= '0;
      right_data_q   <= '0;
      pair_valid_q   <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      ch_q           <= ch_d;
      bitcnt_q       <= bitcnt_d;
      shreg_q        <= shreg_d;
      lrc_prev_q     <= lrc_prev_d;
      lrc_vld_q      <= lrc_vld_d;
      done_q         <= done_d;
      left_seen_q    <= left_seen_d;
      sample_data_q  <= sample_data_d;
      sample_ch_q    <= sample_ch_d;
      sample_valid_q <= sample_valid_d;
      left_data_q    <= left_data_d;
      right_data_q   <= right_data_d;
      pair_valid_q   <= pair_valid_d;
      frame_err_q    <= frame_err_d;
    end
  end

  assign sample_data  = sample_data_q;
  assign sample_ch    = sample_ch_q;
  assign sample_valid = sample_valid_q;
  assign left_data    = left_data_q;
  assign right_data   = right_data_q;
  assign pair_valid   = pair_valid_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_i2s_adc_rx.sv
// Bench for i2s_adc_rx: drives I2S half-frames and scores outputs against a half-frame model.
// bclk runs at mclk/4 with up to 32 bclk per channel so a 16-bit word plus the delay slot fits.
// Expected events carry the exact mclk cycle they must appear on.
module tb_i2s_adc_rx;

  logic        mclk = 1'b0;
  logic        rst, bclk, adclrc, adcdat;
  logic [15:0] sample_data, left_data, right_data;
  logic        sample_ch, sample_valid, pair_valid, frame_err;

  i2s_adc_rx dut (
    .mclk(mclk), .rst(rst), .bclk(bclk), .adclrc(adclrc), .adcdat(adcdat),
    .sample_data(sample_data), .sample_ch(sample_ch), .sample_valid(sample_valid),
    .left_data(left_data), .right_data(right_data),
    .pair_valid(pair_valid), .frame_err(frame_err)
  );

  always #5 mclk = ~mclk;

  int cyc = 0;
  always @(posedge mclk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic        ch;
    logic [15:0] data;
    logic        pair;
    logic [15:0] ldata;
    logic [15:0] rdata;
  } word_ev_t;

  word_ev_t    exp_w[$];
  int          exp_err[$];
  int          sv_cycs[$];
  word_ev_t    mon_e;

  // Half-frame model state.
  int          halves_since_rst;
  bit          pending_err;
  bit          prev_left;
  logic [15:0] exp_left, exp_right;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    halves_since_rst = 0;
    pending_err      = 0;
    prev_left        = 0;
    exp_left         = '0;
    exp_right        = '0;
    exp_w.delete();
    exp_err.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_sdata"}, sample_data, 0);
    chk({tag, "_sch"},   sample_ch, 0);
    chk({tag, "_svld"},  sample_valid, 0);
    chk({tag, "_ldata"}, left_data, 0);
    chk({tag, "_rdata"}, right_data, 0);
    chk({tag, "_pair"},  pair_valid, 0);
    chk({tag, "_ferr"},  frame_err, 0);
  endtask

  // One bclk period: data/lrc change with the falling edge; e0 is the first
  // mclk edge that samples bclk high.
  task automatic bclk_period(input logic lrc, input logic dat, output int e0);
    @(negedge mclk); bclk = 1'b0; adclrc = lrc; adcdat = dat;
    @(negedge mclk);
    @(negedge mclk); bclk = 1'b1; e0 = cyc + 1;
    @(negedge mclk);
  endtask

  // One channel half: delay slot then nbits data bits from payload (MSB first).
  // rel_bit: release reset before that data bit. rst_lsb: reset while the word is in flight.
  task automatic send_half(input logic lrc, input int nbits, input logic [31:0] payload,
                           input int rel_bit, input bit rst_lsb);
    int       e0;
    bit       active;
    word_ev_t ev;
    active = (halves_since_rst > 0);
    bclk_period(lrc, 1'($urandom_range(0, 1)), e0);
    if (pending_err) begin
      exp_err.push_back(e0 + 3);
      prev_left   = 0;
      pending_err = 0;
    end
    for (int i = 0; i < nbits; i++) begin
      if (i == rel_bit) rst = 1'b0;
      bclk_period(lrc, payload[31-i], e0);
      if (active && i == 15) begin
        if (rst_lsb) begin
          repeat (3) @(negedge mclk);
          rst  = 1'b1;
          bclk = 1'b0;
          model_reset();
          repeat (3) @(negedge mclk);
          chk_zero("rst_inflight");
          rst = 1'b0;
          return;
        end
        ev.cyc  = e0 + 4;
        ev.ch   = (lrc == 1'b0) ? 1'b0 : 1'b1;
        ev.data = payload[31:16];
        ev.pair = ev.ch && prev_left;
        prev_left = !ev.ch;
        if (ev.ch) exp_right = ev.data; else exp_left = ev.data;
        ev.ldata = exp_left;
        ev.rdata = exp_right;
        exp_w.push_back(ev);
      end
    end
    if (active && nbits < 16) pending_err = 1;
    halves_since_rst++;
  endtask

  // Scoreboard monitor, sampling away from the active edge.
  always @(negedge mclk) begin
    if (!rst) begin
      if (sample_valid) begin
        sv_cycs.push_back(cyc);
        if (exp_w.size() == 0) begin
          chk("sv_unexpected", 1, 0);
        end else begin
          mon_e = exp_w.pop_front();
          chk("sv_cycle", cyc, mon_e.cyc);
          chk("sv_data", sample_data, mon_e.data);
          chk("sv_ch", sample_ch, mon_e.ch);
          chk("pair_valid", pair_valid, mon_e.pair);
          chk("left_data", left_data, mon_e.ldata);
          chk("right_data", right_data, mon_e.rdata);
        end
      end else if (pair_valid) begin
        chk("pair_unexpected", 1, 0);
      end
      if (frame_err) begin
        if (exp_err.size() == 0) chk("ferr_unexpected", 1, 0);
        else                     chk("ferr_cycle", cyc, exp_err.pop_front());
      end
    end
  end

  initial begin
    int nb_tab[8] = '{31, 24, 16, 20, 12, 31, 17, 15};
    logic lrc;
    rst = 1'b1; bclk = 1'b0; adclrc = 1'b0; adcdat = 1'b0;
    model_reset();
    repeat (5) @(negedge mclk);
    chk_zero("reset");
    rst = 1'b0;

    // Basic pair after reset (first half is a lead-in and never output).
    send_half(1, 31, $urandom, -1, 0);
    send_half(0, 31, {16'h1234, 16'($urandom)}, -1, 0);
    send_half(1, 31, {16'hABCD, 16'($urandom)}, -1, 0);
    chk("t1_left", left_data, 32'h1234);
    chk("t1_right", right_data, 32'hABCD);

    // Extremes and the word interval.
    sv_cycs.delete();
    send_half(0, 31, {16'h8000, 16'h5A5A}, -1, 0);
    send_half(1, 31, {16'h7FFF, 16'hA5A5}, -1, 0);
    send_half(0, 31, {16'hFFFF, 16'h0000}, -1, 0);
    send_half(1, 31, {16'h0000, 16'hFFFF}, -1, 0);
    chk("t2_count", sv_cycs.size(), 4);
    for (int i = 1; i < sv_cycs.size(); i++) chk("t2_interval", sv_cycs[i] - sv_cycs[i-1], 128);

    // Reset released in the middle of a left word.
    @(negedge mclk); rst = 1'b1;
    model_reset();
    repeat (2) @(negedge mclk);
    chk_zero("t3_rst");
    send_half(0, 31, $urandom, 8, 0);
    send_half(1, 31, $urandom, -1, 0);
    send_half(0, 31, $urandom, -1, 0);

    // Truncated words and the exact-length boundary.
    send_half(1, 31, $urandom, -1, 0);
    send_half(0, 31, $urandom, -1, 0);
    send_half(1, 10, $urandom, -1, 0);
    send_half(0, 31, $urandom, -1, 0);
    send_half(1, 31, $urandom, -1, 0);
    send_half(0, 10, $urandom, -1, 0);
    send_half(1, 31, $urandom, -1, 0);
    send_half(0, 16, $urandom, -1, 0);
    send_half(1, 15, $urandom, -1, 0);
    send_half(0, 31, $urandom, -1, 0);
    send_half(1, 31, $urandom, -1, 0);

    // 24-bit slots.
    send_half(0, 24, {24'hC0FFEE, 8'h00}, -1, 0);
    chk("t5_sample", sample_data, 32'hC0FF);
    send_half(1, 24, $urandom, -1, 0);

    // Reset while a completed word is about to be published.
    send_half(0, 31, $urandom, -1, 1);
    send_half(1, 31, $urandom, -1, 0);
    send_half(0, 31, $urandom, -1, 0);
    send_half(1, 31, $urandom, -1, 0);

    // Random half lengths and payloads.
    lrc = 1'b0;
    for (int i = 0; i < 12; i++) begin
      send_half(lrc, nb_tab[$urandom_range(0, 7)], $urandom, -1, 0);
      lrc = ~lrc;
    end
    send_half(0, 31, $urandom, -1, 0);
    send_half(1, 31, $urandom, -1, 0);

    repeat (20) @(negedge mclk);
    chk("words_outstanding", exp_w.size(), 0);
    chk("errs_outstanding", exp_err.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
